mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the core's data-memory store bus, alongside dmem.
//  Core stores to TXDATA push a byte into a FIFO; an FSM serializes 8N1 frames on tx.
//  STATUS is readable; mmio_sel tells the system to mux mmio_read_data over dmem data.
// PARAMETERS
//  BASE_ADDR     32'hFFFF_FF00  word-aligned base; TXDATA=BASE+0, STATUS=BASE+4
//  CLKS_PER_BIT  16             clk cycles per serial bit, >=2
//  FIFO_DEPTH    8              TX FIFO entries, power of 2, >=2
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  reset            in   1   synchronous, active-high
//  dmem_write       in   1   core store strobe (same cycle as addr/data)
//  dmem_addr        in   32  core data address (ALU result)
//  dmem_write_data  in   32  store data; byte in [7:0]
//  mmio_sel         out  1   comb: dmem_addr[31:3]==BASE_ADDR[31:3]
//  mmio_read_data   out  32  comb: STATUS if addr==BASE+4, else 32'h0
//  tx               out  1   serial line, idle high, registered
//  tx_busy          out  1   registered: FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (sync, active-high): FIFO empty, ptrs/count 0, FSM=IDLE, baud ctr 0,
//   tx=1, tx_busy=0, overflow=0. Stores during reset ignored. Reset mid-frame
//   aborts it: tx=1 after that edge, queued bytes discarded.
//  STATUS = {29'b0, overflow, full, tx_busy}.
//  Push: dmem_write && addr==BASE+0 && !full -> write_data[7:0] enqueued at edge.
//   Push while full: byte dropped, overflow<=1 (sticky). full is pre-edge; a
//   same-cycle pop does not rescue the push.
//  Store to BASE+4 clears overflow (data ignored); set-and-clear same cycle -> set wins.
//  Other offsets in the 8-byte window ignored. Loads have no side effects.
//  FIFO: count 0..FIFO_DEPTH; ptrs wrap mod FIFO_DEPTH; push+pop same cycle when
//   not full: count unchanged, both ptrs advance.
//  FSM (each bit CLKS_PER_BIT cycles, baud ctr 0..CLKS_PER_BIT-1, wraps to 0):
//   IDLE : tx=1; if FIFO non-empty: pop into shift reg, ->START.
//   START: tx=0; at bit end ->DATA, bit idx=0.
//   DATA : tx=shift[0], LSB first; at bit end shift right; after bit 7 ->STOP.
//   STOP : tx=1; at bit end: FIFO non-empty -> pop, ->START (no idle gap);
//          else ->IDLE.
//  Latency: store sampled at edge E0; FSM pops at E1 and tx=0 from E1.
//   Frame = 10*CLKS_PER_BIT cycles (11 with parity).
//  tx_busy falls at the edge STOP->IDLE with FIFO empty.
// CONFIGURATION
//  MMIO_UART_PARITY_EN defined: PARITY state between DATA and STOP drives even
//   parity (^byte) for one bit time; 8E1 frame, 11*CLKS_PER_BIT cycles.
//  Undefined: no PARITY state, 8N1 as above. Register map unchanged either way.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
//  1 Reset: hold reset 3 cycles -> tx=1, tx_busy=0, STATUS read = 32'h0.
//  2 Store 32'h0000_00A5 to BASE -> tx low 1 cycle after store edge; bits 1,0,1,0,
//    0,1,0,1 each 4 cycles; stop high; 40-cycle frame; tx_busy=0 after.
//  3 Six back-to-back stores 8'h01..8'h06 while idle -> 01..05 sent (one popped
//    early), 06 dropped; STATUS[2]=1 until store to BASE+4, then 0; frames
//    contiguous, no idle gap.
//  4 Store to BASE+0 during reset=1, and to BASE+8 -> no frame, mmio_sel=0 at BASE+8.
//  5 Assert reset mid-DATA of 8'hFF with 2 queued -> tx=1 next cycle, busy=0, no output.
//  6 MMIO_UART_PARITY_EN: send 8'h07 -> parity bit 1, 44-cycle frame; 8'h03 -> 0.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - core data-memory store bus as seen by the UART MMIO block
interface mmio_uart_tx_if;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_write_data;
  logic        mmio_sel;
  logic [31:0] mmio_read_data;

  modport master (
    output dmem_write, dmem_addr, dmem_write_data,
    input  mmio_sel, mmio_read_data
  );

  modport slave (
    input  dmem_write, dmem_addr, dmem_write_data,
    output mmio_sel, mmio_read_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter (TXDATA/STATUS) with TX FIFO
// Even parity bit (8E1) inserted when MMIO_UART_PARITY_EN is defined; 8N1 otherwise.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          tx_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_n;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          overflow;
  logic          win_hit, at_txdata, at_status;
  logic          full, empty, push, drop, clr, pop, bit_end;
  logic          tx_d, busy_d;
  logic          unused_data;
`ifdef MMIO_UART_PARITY_EN
  logic          par;
`endif

  assign win_hit   = bus.dmem_addr[31:3] == BASE_ADDR[31:3];
  assign at_txdata = win_hit && (bus.dmem_addr[2:0] == 3'd0);
  assign at_status = win_hit && (bus.dmem_addr[2:0] == 3'd4);

  assign bus.mmio_sel       = win_hit;
  assign bus.mmio_read_data = at_status ? {29'b0, overflow, full, tx_busy} : 32'h0;

  // full is the pre-edge value, so a pop in the same cycle never rescues a push
  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign push    = bus.dmem_write && at_txdata && !full;
  assign drop    = bus.dmem_write && at_txdata && full;
  assign clr     = bus.dmem_write && at_status;
  assign bit_end = baud == CW'(CLKS_PER_BIT - 1);
  assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);

  assign unused_data = ^bus.dmem_write_data[31:8];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (!empty) state_n = START;
      START:  if (bit_end) state_n = DATA;
`ifdef MMIO_UART_PARITY_EN
      DATA:   if (bit_end && bit_idx == 3'd7) state_n = PARITY;
      PARITY: if (bit_end) state_n = STOP;
`else
      DATA:   if (bit_end && bit_idx == 3'd7) state_n = STOP;
`endif
      STOP:   if (bit_end) state_n = empty ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  // tx is registered from the next state so the start bit appears on the pop edge
  always_comb begin
    pop       = !empty && ((state == IDLE) || (state == STOP && bit_end));
    shift_n   = shift;
    bit_idx_n = bit_idx;
    if (pop) begin
      shift_n = mem[rd_ptr];
    end else if (state == DATA && bit_end) begin
      shift_n   = shift >> 1;
      bit_idx_n = bit_idx + 3'd1;
    end
    tx_d = 1'b1;
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[0];
`ifdef MMIO_UART_PARITY_EN
      PARITY:  tx_d = par;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_n != IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      baud     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      tx      <= tx_d;
      tx_busy <= busy_d;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      count   <= count_n;
      baud    <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)    par <= 1'b0;
    else if (pop) par <= ^mem[rd_ptr];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= bus.dmem_write_data[7:0];
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_busy;
  int   checks = 0;
  int   passed = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.dmem_write      = 1'b0;
    bus.dmem_addr       = 32'h0;
    bus.dmem_write_data = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_write      = 1'b1;
    bus.dmem_addr       = a;
    bus.dmem_write_data = d;
    tick();
    idle_bus();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic sel);
    bus.dmem_addr = a;
    #1;
    v   = bus.mmio_read_data;
    sel = bus.mmio_sel;
    bus.dmem_addr = 32'h0;
  endtask

  // samples 'skip' onward of a frame whose start bit follows the next edge
  task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
    logic [10:0] bits;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef MMIO_UART_PARITY_EN
    bits[9] = ^b;
    nb = 11;
`else
    nb = 10;
`endif
    for (int k = skip; k < nb * CPB; k++) begin
      tick();
      chk(tag, {31'b0, tx}, {31'b0, bits[k/CPB]});
    end
  endtask

  initial begin
    logic [31:0] v;
    logic        sel;
    logic [5:0]  t3_exp;

    // 1: reset
    idle_bus();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_busy", {31'b0, tx_busy}, 32'h0);
    rd(BASE + 32'd4, v, sel);
    chk("rst_status", v, 32'h0);
    chk("rst_sel", {31'b0, sel}, 32'h1);

    // 2: single byte A5
    store(BASE, 32'h0000_00A5);
    chk("a5_tx_e0", {31'b0, tx}, 32'h1);
    chk("a5_busy_e0", {31'b0, tx_busy}, 32'h1);
    check_frame(8'hA5, 0, "a5_bit");
    tick();
    chk("a5_tx_end", {31'b0, tx}, 32'h1);
    chk("a5_busy_end", {31'b0, tx_busy}, 32'h0);

    // 3: six back-to-back stores, depth 4 -> 06 dropped
    t3_exp = 6'b100001;
    for (int i = 1; i <= 6; i++) begin
      bus.dmem_write      = 1'b1;
      bus.dmem_addr       = BASE;
      bus.dmem_write_data = 32'(i);
      tick();
      chk("burst_tx", {31'b0, tx}, {31'b0, t3_exp[i-1]});
    end
    idle_bus();
    rd(BASE + 32'd4, v, sel);
    chk("burst_status_full", v, 32'h7);
    check_frame(8'h01, 5, "burst_01");
    check_frame(8'h02, 0, "burst_02");
    rd(BASE + 32'd4, v, sel);
    chk("burst_status_mid", v, 32'h5);
    check_frame(8'h03, 0, "burst_03");
    check_frame(8'h04, 0, "burst_04");
    check_frame(8'h05, 0, "burst_05");
    tick();
    chk("burst_tx_end", {31'b0, tx}, 32'h1);
    chk("burst_busy_end", {31'b0, tx_busy}, 32'h0);
    rd(BASE + 32'd4, v, sel);
    chk("ovf_sticky", v, 32'h4);
    store(BASE + 32'd4, 32'h0000_00FF);
    rd(BASE + 32'd4, v, sel);
    chk("ovf_cleared", v, 32'h0);
    repeat (4) begin
      tick();
      chk("status_store_no_tx", {31'b0, tx}, 32'h1);
    end

    // 4: store during reset and outside the register offsets
    reset = 1'b1;
    store(BASE, 32'h0000_0055);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst_store_tx", {31'b0, tx}, 32'h1);
    end
    chk("rst_store_busy", {31'b0, tx_busy}, 32'h0);
    rd(BASE + 32'd8, v, sel);
    chk("b8_sel", {31'b0, sel}, 32'h0);
    chk("b8_data", v, 32'h0);
    rd(BASE + 32'd1, v, sel);
    chk("b1_sel", {31'b0, sel}, 32'h1);
    chk("b1_data", v, 32'h0);
    store(BASE + 32'd8, 32'h0000_0055);
    store(BASE + 32'd1, 32'h0000_0055);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("off_store_tx", {31'b0, tx}, 32'h1);
    end
    chk("off_store_busy", {31'b0, tx_busy}, 32'h0);

    // 5: reset mid-DATA with two bytes queued
    store(BASE, 32'h0000_00FF);
    store(BASE, 32'h0000_0011);
    store(BASE, 32'h0000_0022);
    repeat (8) tick();
    chk("mid_busy", {31'b0, tx_busy}, 32'h1);
    reset = 1'b1;
    tick();
    chk("abort_tx", {31'b0, tx}, 32'h1);
    chk("abort_busy", {31'b0, tx_busy}, 32'h0);
    rd(BASE + 32'd4, v, sel);
    chk("abort_status", v, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("abort_quiet_tx", {31'b0, tx}, 32'h1);
    end
    chk("abort_quiet_busy", {31'b0, tx_busy}, 32'h0);

    // 6: 07 (odd ones -> parity 1) and 03 (parity 0)
    store(BASE, 32'h0000_0007);
    check_frame(8'h07, 0, "b07_bit");
    tick();
    chk("b07_tx_end", {31'b0, tx}, 32'h1);
    chk("b07_busy_end", {31'b0, tx_busy}, 32'h0);
    store(BASE, 32'h0000_0003);
    check_frame(8'h03, 0, "b03_bit");
    tick();
    chk("b03_tx_end", {31'b0, tx}, 32'h1);
    chk("b03_busy_end", {31'b0, tx_busy}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
